tictactoe_board: RTL and testbench

- Board-side responder to the tic-tac-toe game controller. It owns the 3x3 position registers and accepts O and X moves while the controller holds the matching play enable.
- It returns illegal_move, no_space and win to the controller, plus the winner identity and board image for display logic.
- It is a purely sequential storage and judging block and sits directly between the player position inputs and the controller.

---
 rtl/tictactoe_board_if.sv | 31 +++
 rtl/tictactoe_board.sv | 156 +++++++++++++++
 tb/tb_tictactoe_board.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/tictactoe_board_if.sv
// Controller/board bus for the tic-tac-toe board: move requests in, judging results and board image out.
interface tictactoe_board_if #(
  parameter int unsigned CELLS = 9,
  parameter int unsigned POS_W = 4
);
  localparam int unsigned BOARD_W = 2 * CELLS;
  localparam int unsigned CNT_W   = 4;

  logic               new_game;
  logic               player_O_play;
  logic               player_X_play;
  logic [POS_W-1:0]   pos_O;
  logic [POS_W-1:0]   pos_X;
  logic               illegal_move;
  logic               no_space;
  logic               win;
  logic [1:0]         winner;
  logic [BOARD_W-1:0] board;
  logic [CNT_W-1:0]   move_count;
  logic               game_over;

  modport master (
    output new_game, player_O_play, player_X_play, pos_O, pos_X,
    input  illegal_move, no_space, win, winner, board, move_count, game_over
  );

  modport slave (
    input  new_game, player_O_play, player_X_play, pos_O, pos_X,
    output illegal_move, no_space, win, winner, board, move_count, game_over
  );
endinterface

// File: rtl/tictactoe_board.sv
// Tic-tac-toe board store and judge: commits legal O/X moves, flags illegal ones,
// and reports win / draw / game-over with the same-edge timing as the commit.
module tictactoe_board #(
  parameter int unsigned CELLS = 9,
  parameter int unsigned POS_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  tictactoe_board_if.slave  bus
);
  localparam int unsigned BOARD_W = 2 * CELLS;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned N_LINES = 8;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  // Cell indices of the three rows, three columns and two diagonals.
  localparam int unsigned LINES [N_LINES][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_OVER = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [BOARD_W-1:0]   r_board;
  logic [BOARD_W-1:0]   w_board_next;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_next;
  logic                 r_win;
  logic                 w_win_next;
  logic [1:0]           r_winner;
  logic [1:0]           w_winner_next;
  logic                 r_no_space;
  logic                 w_no_space_next;

  logic                 w_move_valid;
  logic [POS_W-1:0]     w_move_pos;
  logic [1:0]           w_move_val;
  logic [1:0]           w_target;
  logic                 w_illegal;
  logic [2:0]           w_judge;

  function automatic logic [1:0] cell_at(input logic [BOARD_W-1:0] b,
                                         input logic [POS_W-1:0]   p);
    logic [1:0] v;
    v = CELL_EMPTY;
    for (int unsigned i = 0; i < CELLS; i++) begin
      if (p == POS_W'(i)) v = b[2*i +: 2];
    end
    return v;
  endfunction

  // Returns {win, winner}; O takes priority if a corrupted board holds both.
  function automatic logic [2:0] judge(input logic [BOARD_W-1:0] b);
    logic       any_line;
    logic       o_line;
    logic       x_line;
    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;
    any_line = 1'b0;
    o_line   = 1'b0;
    x_line   = 1'b0;
    for (int l = 0; l < int'(N_LINES); l++) begin
      c0 = b[2*LINES[l][0] +: 2];
      c1 = b[2*LINES[l][1] +: 2];
      c2 = b[2*LINES[l][2] +: 2];
      if (c0 != CELL_EMPTY && c0 == c1 && c0 == c2) begin
        any_line = 1'b1;
        if (c0 == CELL_O) o_line = 1'b1;
        if (c0 == CELL_X) x_line = 1'b1;
      end
    end
    return {any_line, o_line ? CELL_O : (x_line ? CELL_X : CELL_EMPTY)};
  endfunction

  // O has priority; a simultaneous X request is dropped without effect.
  always_comb begin
    w_move_valid = bus.player_O_play | bus.player_X_play;
    w_move_pos   = bus.player_O_play ? bus.pos_O : bus.pos_X;
    w_move_val   = bus.player_O_play ? CELL_O : CELL_X;
    w_target     = cell_at(r_board, w_move_pos);
    w_illegal    = w_move_valid &&
                   ((w_move_pos > POS_W'(CELLS - 1)) ||
                    (w_target != CELL_EMPTY) ||
                    (r_state == ST_OVER));
  end

  // Next board/count, then judge the next board so results land on the commit edge.
  always_comb begin
    w_state_next    = r_state;
    w_board_next    = r_board;
    w_count_next    = r_count;
    w_win_next      = r_win;
    w_winner_next   = r_winner;
    w_no_space_next = r_no_space;
    w_judge         = 3'b000;

    if (bus.new_game) begin
      w_state_next    = ST_PLAY;
      w_board_next    = '0;
      w_count_next    = '0;
      w_win_next      = 1'b0;
      w_winner_next   = CELL_EMPTY;
      w_no_space_next = 1'b0;
    end else begin
      if (w_move_valid && !w_illegal) begin
        for (int unsigned i = 0; i < CELLS; i++) begin
          if (w_move_pos == POS_W'(i)) w_board_next[2*i +: 2] = w_move_val;
        end
        w_count_next = (r_count >= CNT_W'(CELLS)) ? r_count : r_count + CNT_W'(1);
      end
      w_judge         = judge(w_board_next);
      w_win_next      = w_judge[2];
      w_winner_next   = w_judge[1:0];
      w_no_space_next = (w_count_next == CNT_W'(CELLS));
      if (r_state == ST_PLAY && (w_win_next || w_no_space_next)) begin
        w_state_next = ST_OVER;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_PLAY;
      r_board    <= '0;
      r_count    <= '0;
      r_win      <= 1'b0;
      r_winner   <= CELL_EMPTY;
      r_no_space <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_board    <= w_board_next;
      r_count    <= w_count_next;
      r_win      <= w_win_next;
      r_winner   <= w_winner_next;
      r_no_space <= w_no_space_next;
    end
  end

  assign bus.illegal_move = w_illegal;
  assign bus.no_space     = r_no_space;
  assign bus.win          = r_win;
  assign bus.winner       = r_winner;
  assign bus.board        = r_board;
  assign bus.move_count   = r_count;
  assign bus.game_over    = (r_state == ST_OVER);
endmodule

// File: tb/tb_tictactoe_board.sv
// Table-driven bench for tictactoe_board: scripted games with hand-computed boards and flags.
module tb_tictactoe_board;
  localparam logic [1:0] O = 2'b10;
  localparam logic [1:0] X = 2'b01;
  localparam logic [1:0] N = 2'b00;

  logic clock = 1'b0;
  logic reset;

  tictactoe_board_if bus ();

  tictactoe_board dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ng;
    logic        op;
    logic        xp;
    logic [3:0]  po;
    logic [3:0]  px;
    logic        e_ill;
    logic [17:0] e_board;
    logic [3:0]  e_cnt;
    logic        e_win;
    logic [1:0]  e_wnr;
    logic        e_ns;
    logic        e_ov;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [17:0] cl(input int i, input logic [1:0] v);
    logic [17:0] r;
    r = 18'(v) << (2 * i);
    return r;
  endfunction

  function automatic vec_t mv(input logic op, input logic xp,
                              input logic [3:0] po, input logic [3:0] px,
                              input logic ill, input logic [17:0] b,
                              input logic [3:0] n, input logic w,
                              input logic [1:0] wn, input logic ns,
                              input logic ov);
    vec_t v;
    v.ng = 1'b0; v.op = op; v.xp = xp; v.po = po; v.px = px;
    v.e_ill = ill; v.e_board = b; v.e_cnt = n; v.e_win = w;
    v.e_wnr = wn; v.e_ns = ns; v.e_ov = ov;
    return v;
  endfunction

  function automatic vec_t ngv(input logic op, input logic [3:0] po, input logic ill);
    vec_t v;
    v = mv(op, 1'b0, po, 4'd0, ill, 18'd0, 4'd0, 1'b0, N, 1'b0, 1'b0);
    v.ng = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [17:0] b, input logic [3:0] n,
                             input logic w, input logic [1:0] wn, input logic ns,
                             input logic ov);
    chk({tag, " board"},      32'(bus.board),      32'(b));
    chk({tag, " move_count"}, 32'(bus.move_count), 32'(n));
    chk({tag, " win"},        32'(bus.win),        32'(w));
    chk({tag, " winner"},     32'(bus.winner),     32'(wn));
    chk({tag, " no_space"},   32'(bus.no_space),   32'(ns));
    chk({tag, " game_over"},  32'(bus.game_over),  32'(ov));
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clock);
    bus.new_game      = v.ng;
    bus.player_O_play = v.op;
    bus.player_X_play = v.xp;
    bus.pos_O         = v.po;
    bus.pos_X         = v.px;
    #1;
    chk({tag, " illegal_move"}, 32'(bus.illegal_move), 32'(v.e_ill));
    @(posedge clock);
    #1;
    check_state(tag, v.e_board, v.e_cnt, v.e_win, v.e_wnr, v.e_ns, v.e_ov);
  endtask

  task automatic idle();
    @(negedge clock);
    bus.new_game      = 1'b0;
    bus.player_O_play = 1'b0;
    bus.player_X_play = 1'b0;
    bus.pos_O         = 4'd0;
    bus.pos_X         = 4'd0;
  endtask

  initial begin
    logic [17:0] b;

    // Win by O on the 2-4-6 diagonal, then a move after game over.
    b = cl(4, O);            vecs.push_back(mv(1,0,4'd4,4'd0,0,b,4'd1,0,N,0,0));
    b = b | cl(0, X);        vecs.push_back(mv(0,1,4'd0,4'd0,0,b,4'd2,0,N,0,0));
    b = b | cl(2, O);        vecs.push_back(mv(1,0,4'd2,4'd0,0,b,4'd3,0,N,0,0));
    b = b | cl(1, X);        vecs.push_back(mv(0,1,4'd0,4'd1,0,b,4'd4,0,N,0,0));
    b = b | cl(6, O);        vecs.push_back(mv(1,0,4'd6,4'd0,0,b,4'd5,1,O,0,1));
    vecs.push_back(mv(0,1,4'd0,4'd8,1,b,4'd5,1,O,0,1));
    vecs.push_back(ngv(0, 4'd0, 0));

    // Occupied cell, out-of-range position, then new_game cancelling an offered move.
    b = cl(4, O);            vecs.push_back(mv(1,0,4'd4,4'd0,0,b,4'd1,0,N,0,0));
    vecs.push_back(mv(0,1,4'd0,4'd4,1,b,4'd1,0,N,0,0));
    vecs.push_back(mv(1,0,4'd9,4'd0,1,b,4'd1,0,N,0,0));
    vecs.push_back(mv(0,1,4'd0,4'd15,1,b,4'd1,0,N,0,0));
    b = b | cl(0, X);        vecs.push_back(mv(0,1,4'd0,4'd0,0,b,4'd2,0,N,0,0));
    vecs.push_back(ngv(1, 4'd3, 0));

    // Both enables: O wins arbitration; X ignored even when O is rejected.
    b = cl(3, O);            vecs.push_back(mv(1,1,4'd3,4'd5,0,b,4'd1,0,N,0,0));
    vecs.push_back(mv(1,1,4'd3,4'd5,1,b,4'd1,0,N,0,0));
    vecs.push_back(ngv(0, 4'd0, 0));

    // Draw: X0,O1,X2,O4,X3,O5,X7,O6,X8.
    b = cl(0, X);            vecs.push_back(mv(0,1,4'd0,4'd0,0,b,4'd1,0,N,0,0));
    b = b | cl(1, O);        vecs.push_back(mv(1,0,4'd1,4'd0,0,b,4'd2,0,N,0,0));
    b = b | cl(2, X);        vecs.push_back(mv(0,1,4'd0,4'd2,0,b,4'd3,0,N,0,0));
    b = b | cl(4, O);        vecs.push_back(mv(1,0,4'd4,4'd0,0,b,4'd4,0,N,0,0));
    b = b | cl(3, X);        vecs.push_back(mv(0,1,4'd0,4'd3,0,b,4'd5,0,N,0,0));
    b = b | cl(5, O);        vecs.push_back(mv(1,0,4'd5,4'd0,0,b,4'd6,0,N,0,0));
    b = b | cl(7, X);        vecs.push_back(mv(0,1,4'd0,4'd7,0,b,4'd7,0,N,0,0));
    b = b | cl(6, O);        vecs.push_back(mv(1,0,4'd6,4'd0,0,b,4'd8,0,N,0,0));
    b = b | cl(8, X);        vecs.push_back(mv(0,1,4'd0,4'd8,0,b,4'd9,0,N,1,1));
    vecs.push_back(mv(1,0,4'd5,4'd0,1,b,4'd9,0,N,1,1));
    vecs.push_back(ngv(0, 4'd0, 0));

    // Ninth move X8 completes 0-4-8: win and no_space on the same edge.
    b = cl(0, X);            vecs.push_back(mv(0,1,4'd0,4'd0,0,b,4'd1,0,N,0,0));
    b = b | cl(2, O);        vecs.push_back(mv(1,0,4'd2,4'd0,0,b,4'd2,0,N,0,0));
    b = b | cl(1, X);        vecs.push_back(mv(0,1,4'd0,4'd1,0,b,4'd3,0,N,0,0));
    b = b | cl(3, O);        vecs.push_back(mv(1,0,4'd3,4'd0,0,b,4'd4,0,N,0,0));
    b = b | cl(4, X);        vecs.push_back(mv(0,1,4'd0,4'd4,0,b,4'd5,0,N,0,0));
    b = b | cl(6, O);        vecs.push_back(mv(1,0,4'd6,4'd0,0,b,4'd6,0,N,0,0));
    b = b | cl(5, X);        vecs.push_back(mv(0,1,4'd0,4'd5,0,b,4'd7,0,N,0,0));
    b = b | cl(7, O);        vecs.push_back(mv(1,0,4'd7,4'd0,0,b,4'd8,0,N,0,0));
    b = b | cl(8, X);        vecs.push_back(mv(0,1,4'd0,4'd8,0,b,4'd9,1,X,1,1));
    vecs.push_back(ngv(0, 4'd0, 0));

    // Reset state.
    reset             = 1'b1;
    bus.new_game      = 1'b0;
    bus.player_O_play = 1'b0;
    bus.player_X_play = 1'b0;
    bus.pos_O         = 4'd0;
    bus.pos_X         = 4'd0;
    #12;
    chk("reset illegal_move", 32'(bus.illegal_move), 32'd0);
    check_state("reset", 18'd0, 4'd0, 1'b0, N, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Mid-game asynchronous reset clears before any clock edge.
    b = cl(0, O);        apply(mv(1,0,4'd0,4'd0,0,b,4'd1,0,N,0,0), "r1");
    b = b | cl(1, X);    apply(mv(0,1,4'd0,4'd1,0,b,4'd2,0,N,0,0), "r2");
    b = b | cl(2, O);    apply(mv(1,0,4'd2,4'd0,0,b,4'd3,0,N,0,0), "r3");
    b = b | cl(3, X);    apply(mv(0,1,4'd0,4'd3,0,b,4'd4,0,N,0,0), "r4");
    idle();
    #1;
    reset = 1'b1;
    #1;
    check_state("async_reset", 18'd0, 4'd0, 1'b0, N, 1'b0, 1'b0);
    #1;
    reset = 1'b0;

    // Held legal move commits once, then reads as illegal.
    b = cl(4, O);        apply(mv(1,0,4'd4,4'd0,0,b,4'd1,0,N,0,0), "h1");
    apply(mv(1,0,4'd4,4'd0,1,b,4'd1,0,N,0,0), "h2");
    idle();
    #1;
    chk("idle illegal_move", 32'(bus.illegal_move), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
